// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b): one bit per clock, LSB first, single borrow flop.
// Start/done handshake; result flags are updated only when the last bit has been produced.
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   sa_reg, sa_next;
    logic [WIDTH-1:0]   sb_reg, sb_next;
    logic [WIDTH-1:0]   sr_reg, sr_next;
    logic               borrow_reg, borrow_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               a_msb_reg, a_msb_next;
    logic               b_msb_reg, b_msb_next;

    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [WIDTH-1:0]   diff_reg, diff_next;
    logic               borrow_out_reg, borrow_out_next;
    logic               overflow_reg, overflow_next;
    logic               zero_reg, zero_next;

    // Single full-subtractor cell shared by every bit position.
    logic               bit_d;
    logic               bit_borrow;
    logic [WIDTH-1:0]   result_full;

    assign bit_d       = sa_reg[0] ^ sb_reg[0] ^ borrow_reg;
    assign bit_borrow  = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & borrow_reg);
    assign result_full = {bit_d, sr_reg[WIDTH-1:1]};

    always_comb begin
        state_next      = state_reg;
        sa_next         = sa_reg;
        sb_next         = sb_reg;
        sr_next         = sr_reg;
        borrow_next     = borrow_reg;
        cnt_next        = cnt_reg;
        a_msb_next      = a_msb_reg;
        b_msb_next      = b_msb_reg;
        done_next       = 1'b0;
        diff_next       = diff_reg;
        borrow_out_next = borrow_out_reg;
        overflow_next   = overflow_reg;
        zero_next       = zero_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    sa_next     = a;
                    sb_next     = b;
                    a_msb_next  = a[WIDTH-1];
                    b_msb_next  = b[WIDTH-1];
                    borrow_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                sa_next     = sa_reg >> 1;
                sb_next     = sb_reg >> 1;
                sr_next     = result_full;
                borrow_next = bit_borrow;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_CNT) begin
                    // Publish everything at once so partial results never reach the ports.
                    state_next      = DONE;
                    diff_next       = result_full;
                    borrow_out_next = bit_borrow;
                    overflow_next   = (a_msb_reg != b_msb_reg) && (bit_d != a_msb_reg);
                    zero_next       = (result_full == '0);
                    done_next       = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sa_reg         <= '0;
            sb_reg         <= '0;
            sr_reg         <= '0;
            borrow_reg     <= 1'b0;
            cnt_reg        <= '0;
            a_msb_reg      <= 1'b0;
            b_msb_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            zero_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sa_reg         <= sa_next;
            sb_reg         <= sb_next;
            sr_reg         <= sr_next;
            borrow_reg     <= borrow_next;
            cnt_reg        <= cnt_next;
            a_msb_reg      <= a_msb_next;
            b_msb_reg      <= b_msb_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            diff_reg       <= diff_next;
            borrow_out_reg <= borrow_out_next;
            overflow_reg   <= overflow_next;
            zero_reg       <= zero_next;
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign diff       = diff_reg;
    assign borrow_out = borrow_out_reg;
    assign overflow   = overflow_reg;
    assign zero       = zero_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor: latency, flags, held start, ignored start, mid-op reset.
module tb_serial_subtractor;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    int vectors     = 0;
    int miscompares = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op with a one-cycle start pulse, wait (bounded) for done, check result and timing.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input logic [WIDTH-1:0] exp_diff, input logic exp_borrow,
                          input logic exp_ovf, input logic exp_zero);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        a = op_a; b = op_b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
        end
        $display("op %s: a=0x%04h b=0x%04h diff=0x%04h borrow=%0b ovf=%0b zero=%0b latency=%0d",
                 tag, op_a, op_b, diff, borrow_out, overflow, zero, cyc);
        check_val({tag, ".done_seen"}, 32'(done), 32'd1);
        check_val({tag, ".latency"}, 32'(cyc), 32'd16);
        check_val({tag, ".diff"}, 32'(diff), 32'(exp_diff));
        check_val({tag, ".borrow"}, 32'(borrow_out), 32'(exp_borrow));
        check_val({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
        check_val({tag, ".zero"}, 32'(zero), 32'(exp_zero));
        @(negedge clk);
        check_val({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd17);
        check_val({tag, ".done_pulse"}, 32'(done), 32'd0);
        check_val({tag, ".busy_after"}, 32'(busy), 32'd0);
        check_val({tag, ".diff_hold"}, 32'(diff), 32'(exp_diff));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, ".idle_reached"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n_done;
        int first_t;
        int second_t;
        logic [WIDTH-1:0] seen_diff;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check_val("reset.busy", 32'(busy), 32'd0);
        check_val("reset.done", 32'(done), 32'd0);
        check_val("reset.diff", 32'(diff), 32'd0);
        check_val("reset.flags", {29'd0, borrow_out, overflow, zero}, 32'd0);
        rst_n = 1'b1;

        run_op("5-3",        16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_op("3-5",        16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        run_op("8000-1",     16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("7FFF-FFFF",  16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0);
        run_op("1234-1234",  16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Start held high for 40 cycles: back-to-back ops, done spaced by WIDTH+2.
        @(negedge clk);
        a = 16'h0000; b = 16'h0000; start = 1'b1;
        n_done = 0; first_t = -1; second_t = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_t < 0) first_t = t;
                else if (second_t < 0) second_t = t;
            end
        end
        start = 1'b0;
        $display("op held_start: done_count=%0d first=%0d second=%0d diff=0x%04h zero=%0b",
                 n_done, first_t, second_t, diff, zero);
        check_val("held.done_count", 32'(n_done), 32'd2);
        check_val("held.spacing", 32'(second_t - first_t), 32'd18);
        check_val("held.diff", 32'(diff), 32'd0);
        check_val("held.zero", 32'(zero), 32'd1);
        wait_idle("held");

        // Operands and start change mid-run: captured values must be used, start ignored.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'h1111; b = 16'h2222;
        n_done = 0; seen_diff = '0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                seen_diff = diff;
            end
        end
        $display("op midrun_change: done_count=%0d diff=0x%04h", n_done, seen_diff);
        check_val("midrun.done_count", 32'(n_done), 32'd1);
        check_val("midrun.diff", 32'(seen_diff), 32'h00FE);
        wait_idle("midrun");

        // Asynchronous reset in the middle of a run clears everything without a done.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("op midrun_reset: busy=%0b done=%0b diff=0x%04h", busy, done, diff);
        check_val("rst.busy", 32'(busy), 32'd0);
        check_val("rst.done", 32'(done), 32'd0);
        check_val("rst.diff", 32'(diff), 32'd0);
        check_val("rst.flags", {29'd0, borrow_out, overflow, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_val("rst.no_done", 32'(n_done), 32'd0);

        run_op("A5A5-5A5A",  16'hA5A5, 16'h5A5A, 16'h4B4B, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
